// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus: slave FSM states, default
// widths and the latched operation encoding.
package bus_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_WRITE,
    S_RREQ,
    S_RCAP,
    S_RDATA,
    S_DONE
  } state_e;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } op_e;

endpackage

// File: rtl/bus_shift_reg.sv
// LSB-first shift register: serial bits enter at the MSB and move toward bit 0.
// A parallel load takes priority over shifting.
module bus_shift_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         ld_i,
  input  logic [W-1:0] ld_data_i,
  input  logic         en_i,
  input  logic         sin_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (ld_i) begin
      q_d = ld_data_i;
    end else if (en_i) begin
      q_d = {sin_i, q_q[W-1:1]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/slave_in.sv
// Slave endpoint of the serial system bus: deserialises address/burst/write
// data, drives single-cycle memory strobes and serialises read data back.
module slave_in
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic              master_valid,
  input  logic              master_ready,
  input  logic              write_en,
  input  logic              read_en,
  input  logic              rx_address,
  input  logic              rx_burst_number,
  input  logic              rx_data,
  output logic              slave_ready,
  output logic              slave_valid,
  output logic              tx_data,
  output logic              rx_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned CNT_W = $clog2(MAX_W);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             alive_q;

  logic              addr_en, wd_en, rd_ld, rd_en, beat_end, last_beat, start;
  logic [ADDR_W-1:0] addr_sr, burst_sr;
  logic [DATA_W-1:0] wdata_sr, rdata_sr;
  logic              unused_rd_hi;

  // Address and burst registers double as the beat address and the
  // remaining-beat counter: each beat end reloads them with +1 / -1.
  bus_shift_reg #(.W(ADDR_W)) u_addr (
    .clk_i(clk), .rst_ni(reset), .ld_i(beat_end), .ld_data_i(addr_sr + ADDR_W'(1)),
    .en_i(addr_en), .sin_i(rx_address), .q_o(addr_sr)
  );

  bus_shift_reg #(.W(ADDR_W)) u_burst (
    .clk_i(clk), .rst_ni(reset), .ld_i(beat_end), .ld_data_i(burst_sr - ADDR_W'(1)),
    .en_i(addr_en), .sin_i(rx_burst_number), .q_o(burst_sr)
  );

  bus_shift_reg #(.W(DATA_W)) u_wdata (
    .clk_i(clk), .rst_ni(reset), .ld_i(1'b0), .ld_data_i('0),
    .en_i(wd_en), .sin_i(rx_data), .q_o(wdata_sr)
  );

  bus_shift_reg #(.W(DATA_W)) u_rdata (
    .clk_i(clk), .rst_ni(reset), .ld_i(rd_ld), .ld_data_i(mem_rdata),
    .en_i(rd_en), .sin_i(1'b0), .q_o(rdata_sr)
  );

  assign unused_rd_hi = ^rdata_sr[DATA_W-1:1];

  // A burst value of 0 or 1 both mean this is the final beat.
  assign last_beat = (burst_sr <= ADDR_W'(1));
  assign start     = sel & master_valid & slave_ready & (write_en ^ read_en);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    slave_ready = 1'b0;
    slave_valid = 1'b0;
    rx_done     = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    addr_en     = 1'b0;
    wd_en       = 1'b0;
    rd_ld       = 1'b0;
    rd_en       = 1'b0;
    beat_end    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        slave_ready = alive_q & sel;
        if (start) begin
          op_d    = write_en ? OP_WRITE : OP_READ;
          addr_en = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (!sel) begin
          state_d = S_IDLE;
        end else begin
          addr_en = 1'b1;
          if (cnt_q == CNT_W'(ADDR_W - 1)) begin
            cnt_d   = '0;
            state_d = (op_q == OP_WRITE) ? S_WDATA : S_RREQ;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_WDATA: begin
        if (!sel) begin
          state_d = S_IDLE;
        end else begin
          wd_en = 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            cnt_d   = '0;
            state_d = S_WRITE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_WRITE: begin
        // The strobe is issued even if sel drops in this cycle.
        mem_we   = 1'b1;
        beat_end = 1'b1;
        if (!sel)           state_d = S_IDLE;
        else if (last_beat) state_d = S_DONE;
        else                state_d = S_WDATA;
      end
      S_RREQ: begin
        if (!sel) begin
          state_d = S_IDLE;
        end else begin
          mem_re  = 1'b1;
          state_d = S_RCAP;
        end
      end
      S_RCAP: begin
        if (!sel) begin
          state_d = S_IDLE;
        end else begin
          rd_ld   = 1'b1;
          state_d = S_RDATA;
        end
      end
      S_RDATA: begin
        if (!sel) begin
          state_d = S_IDLE;
        end else if (master_ready) begin
          slave_valid = 1'b1;
          rd_en       = 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            cnt_d    = '0;
            beat_end = 1'b1;
            state_d  = last_beat ? S_DONE : S_RREQ;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        rx_done = sel;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE && state_q != S_IDLE) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_WRITE;
      cnt_q   <= '0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      alive_q <= 1'b1;
    end
  end

  assign mem_addr  = addr_sr;
  assign mem_wdata = wdata_sr;
  assign tx_data   = slave_valid & rdata_sr[0];

endmodule

// File: tb/tb_slave_in.sv
// Bench for slave_in: serial master driver, memory model and transaction-level
// expectations (beat addresses, data bytes, done pulses, latency).
`timescale 1ns/1ps
module tb_slave_in;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sel = 1'b0, master_valid = 1'b0, master_ready = 1'b0;
  logic write_en = 1'b0, read_en = 1'b0;
  logic rx_address = 1'b0, rx_burst_number = 1'b0, rx_data = 1'b0;
  logic slave_ready, slave_valid, tx_data, rx_done, mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int errors = 0;
  int checks = 0;

  int unsigned cyc = 0, start_cyc = 0, first_we_cyc = 0;
  bit          got_we = 1'b0;
  int          done_cnt = 0;
  logic [AW-1:0] we_addr[$];
  logic [DW-1:0] we_data[$];
  logic [AW-1:0] re_addr[$];
  bit            tx_bits[$];
  int unsigned   tx_cyc[$];
  logic [DW-1:0] mem[0:4095];
  logic [DW-1:0] wq[$];
  int            stall_at = -1;
  int            stall_len = 0;

  slave_in #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .sel(sel), .master_valid(master_valid),
    .master_ready(master_ready), .write_en(write_en), .read_en(read_en),
    .rx_address(rx_address), .rx_burst_number(rx_burst_number), .rx_data(rx_data),
    .slave_ready(slave_ready), .slave_valid(slave_valid), .tx_data(tx_data),
    .rx_done(rx_done), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and memory model, sampled mid-cycle.
  always @(negedge clk) begin
    if (sel && master_valid && slave_ready && (write_en ^ read_en)) start_cyc = cyc;
    if (mem_we) begin
      we_addr.push_back(mem_addr);
      we_data.push_back(mem_wdata);
      mem[mem_addr] = mem_wdata;
      if (!got_we) begin got_we = 1'b1; first_we_cyc = cyc; end
    end
    if (mem_re) begin
      re_addr.push_back(mem_addr);
      mem_rdata = mem[mem_addr];
    end
    if (slave_valid) begin tx_bits.push_back(tx_data); tx_cyc.push_back(cyc); end
    if (rx_done) done_cnt++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    we_addr.delete(); we_data.delete(); re_addr.delete();
    tx_bits.delete(); tx_cyc.delete();
    done_cnt = 0; got_we = 1'b0;
  endtask

  task automatic idle_inputs();
    master_valid = 1'b0; write_en = 1'b0; read_en = 1'b0; master_ready = 1'b0;
    rx_address = 1'b0; rx_burst_number = 1'b0; rx_data = 1'b0;
  endtask

  task automatic send_addr(input bit is_wr, input logic [AW-1:0] a, input logic [AW-1:0] b);
    sel = 1'b1; master_valid = 1'b1; write_en = is_wr; read_en = !is_wr;
    for (int unsigned i = 0; i < AW; i++) begin
      rx_address = a[i]; rx_burst_number = b[i];
      step();
      write_en = 1'b0; read_en = 1'b0;
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [AW-1:0] b);
    int unsigned n;
    logic [DW-1:0] d;
    n = (b == 0) ? 1 : int'(b);
    send_addr(1'b1, a, b);
    for (int unsigned k = 0; k < n; k++) begin
      d = wq[k];
      for (int unsigned j = 0; j < DW; j++) begin rx_data = d[j]; step(); end
      step();
    end
    step();
    idle_inputs();
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] b, output bit timeout);
    int unsigned guard;
    bit stalled;
    guard = 0; stalled = 1'b0; timeout = 1'b1;
    master_ready = 1'b1;
    send_addr(1'b0, a, b);
    while (guard < 600) begin
      step(); guard++;
      if (done_cnt > 0) begin timeout = 1'b0; break; end
      if (!stalled && stall_at >= 0 && tx_bits.size() == stall_at) begin
        master_ready = 1'b0;
        repeat (stall_len) step();
        master_ready = 1'b1;
        stalled = 1'b1;
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      {sel, master_valid, master_ready, write_en, read_en} = 5'($urandom);
      {rx_address, rx_burst_number, rx_data} = 3'($urandom);
      mem_rdata = DW'($urandom);
      @(negedge clk);
      checks++;
      if ({slave_ready, slave_valid, tx_data, rx_done, mem_we, mem_re, mem_addr, mem_wdata} !== '0)
        begin errors++; $display("FAIL reset_outputs[%0d]: got rdy=%b val=%b tx=%b done=%b we=%b re=%b addr=%h wd=%h want all 0",
                                 i, slave_ready, slave_valid, tx_data, rx_done, mem_we, mem_re, mem_addr, mem_wdata); end
    end
    idle_inputs(); sel = 1'b1;
    step(); reset = 1'b1;
    step(); @(negedge clk);
    checks++;
    if (slave_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", slave_ready); end
  endtask

  task automatic test_single_write();
    clear_mon();
    wq = '{8'hA5};
    do_write(12'h5C3, 12'd1);
    @(negedge clk);
    checks++;
    if (we_addr.size() != 1) begin errors++; $display("FAIL sw_count: got %0d want 1", we_addr.size()); end
    else begin
      checks++;
      if (we_addr[0] !== 12'h5C3 || we_data[0] !== 8'hA5)
        begin errors++; $display("FAIL sw_beat: got %h/%h want 5c3/a5", we_addr[0], we_data[0]); end
    end
    checks++;
    if (!got_we || first_we_cyc - start_cyc != AW + DW)
      begin errors++; $display("FAIL sw_latency: got %0d want %0d", first_we_cyc - start_cyc, AW + DW); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL sw_done: got %0d want 1", done_cnt); end
    checks++;
    if (slave_ready !== 1'b1) begin errors++; $display("FAIL sw_ready_after: got %b want 1", slave_ready); end
  endtask

  task automatic test_read_burst();
    bit to;
    logic [DW-1:0] exp_b[3];
    logic [DW-1:0] got;
    clear_mon();
    mem[12'hE5C] = 8'h11; mem[12'hE5D] = 8'h22; mem[12'hE5E] = 8'h33;
    exp_b = '{8'h11, 8'h22, 8'h33};
    do_read(12'hE5C, 12'd3, to);
    checks++;
    if (to) begin errors++; $display("FAIL rd_timeout: got timeout want done"); end
    checks++;
    if (re_addr.size() != 3 || tx_bits.size() != 3 * DW)
      begin errors++; $display("FAIL rd_counts: got re=%0d bits=%0d want 3/24", re_addr.size(), tx_bits.size()); end
    else begin
      for (int k = 0; k < 3; k++) begin
        for (int j = 0; j < DW; j++) got[j] = tx_bits[k*DW + j];
        checks++;
        if (re_addr[k] !== AW'(12'hE5C + k) || got !== exp_b[k])
          begin errors++; $display("FAIL rd_beat[%0d]: got %h/%h want %h/%h", k, re_addr[k], got, AW'(12'hE5C + k), exp_b[k]); end
      end
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL rd_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_wrap_zero();
    clear_mon();
    wq = '{8'h01, 8'h02};
    do_write(12'hFFF, 12'd2);
    checks++;
    if (we_addr.size() != 2) begin errors++; $display("FAIL wrap_count: got %0d want 2", we_addr.size()); end
    else begin
      checks++;
      if (we_addr[0] !== 12'hFFF || we_data[0] !== 8'h01 || we_addr[1] !== 12'h000 || we_data[1] !== 8'h02)
        begin errors++; $display("FAIL wrap_beats: got %h/%h %h/%h want fff/01 000/02", we_addr[0], we_data[0], we_addr[1], we_data[1]); end
    end
    clear_mon();
    wq = '{8'h3C, 8'hC3};
    do_write(12'h123, 12'd0);
    checks++;
    if (we_addr.size() != 1 || done_cnt != 1)
      begin errors++; $display("FAIL zero_burst: got writes=%0d done=%0d want 1/1", we_addr.size(), done_cnt); end
    else begin
      checks++;
      if (we_addr[0] !== 12'h123 || we_data[0] !== 8'h3C)
        begin errors++; $display("FAIL zero_burst_beat: got %h/%h want 123/3c", we_addr[0], we_data[0]); end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    logic [AW-1:0] a;
    logic [DW-1:0] exp_v, got;
    clear_mon();
    a = AW'($urandom);
    exp_v = DW'($urandom);
    mem[a] = exp_v;
    stall_at = 4; stall_len = 5;
    do_read(a, 12'd1, to);
    stall_at = -1;
    checks++;
    if (to || tx_bits.size() != DW)
      begin errors++; $display("FAIL bp_bits: got timeout=%0d bits=%0d want 0/%0d", to, tx_bits.size(), DW); end
    else begin
      for (int j = 0; j < DW; j++) got[j] = tx_bits[j];
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL bp_byte: got %h want %h", got, exp_v); end
      checks++;
      if (tx_cyc[4] - tx_cyc[3] != 6)
        begin errors++; $display("FAIL bp_gap: got %0d idle cycles want 5", tx_cyc[4] - tx_cyc[3] - 1); end
    end
  endtask

  task automatic test_abort_illegal();
    clear_mon();
    wq = '{8'hFF};
    send_addr(1'b1, AW'($urandom), 12'd1);
    for (int j = 0; j < 3; j++) begin rx_data = 1'b1; step(); end
    sel = 1'b0;
    repeat (15) step();
    idle_inputs(); sel = 1'b1;
    @(negedge clk);
    checks++;
    if (we_addr.size() != 0 || done_cnt != 0)
      begin errors++; $display("FAIL abort_events: got writes=%0d done=%0d want 0/0", we_addr.size(), done_cnt); end
    checks++;
    if (slave_ready !== 1'b1) begin errors++; $display("FAIL abort_idle: got ready=%b want 1", slave_ready); end
    step();
    clear_mon();
    master_valid = 1'b1; write_en = 1'b1; read_en = 1'b1;
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (slave_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready: got %b want 1", slave_ready); end
    repeat (30) step();
    checks++;
    if (we_addr.size() != 0 || re_addr.size() != 0 || done_cnt != 0)
      begin errors++; $display("FAIL illegal_events: got we=%0d re=%0d done=%0d want 0/0/0", we_addr.size(), re_addr.size(), done_cnt); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    send_addr(1'b1, 12'hABC, 12'd2);
    rx_data = 1'b1; step(); step();
    reset = 1'b0;
    #2;
    checks++;
    if ({slave_ready, slave_valid, tx_data, rx_done, mem_we, mem_re, mem_addr, mem_wdata} !== '0)
      begin errors++; $display("FAIL reset_mid_clear: got addr=%h wd=%h rdy=%b want all 0", mem_addr, mem_wdata, slave_ready); end
    step(); idle_inputs(); reset = 1'b1;
    repeat (25) step();
    @(negedge clk);
    checks++;
    if (we_addr.size() != 0 || done_cnt != 0 || slave_ready !== 1'b1)
      begin errors++; $display("FAIL reset_mid_after: got we=%0d done=%0d rdy=%b want 0/0/1", we_addr.size(), done_cnt, slave_ready); end
    step();
  endtask

  task automatic test_random();
    bit is_wr, to;
    logic [AW-1:0] a, b, ea;
    int unsigned n;
    logic [DW-1:0] exp_r[$];
    logic [DW-1:0] got;
    for (int t = 0; t < 6; t++) begin
      clear_mon();
      is_wr = 1'($urandom);
      a = AW'($urandom);
      b = AW'($urandom_range(0, 4));
      n = (b == 0) ? 1 : int'(b);
      if (is_wr) begin
        wq.delete();
        for (int unsigned k = 0; k < n; k++) wq.push_back(DW'($urandom));
        do_write(a, b);
        checks++;
        if (we_addr.size() != n || done_cnt != 1)
          begin errors++; $display("FAIL rnd_wr_count[%0d]: got %0d/%0d want %0d/1", t, we_addr.size(), done_cnt, n); end
        else for (int unsigned k = 0; k < n; k++) begin
          ea = a + AW'(k);
          checks++;
          if (we_addr[k] !== ea || we_data[k] !== wq[k])
            begin errors++; $display("FAIL rnd_wr_beat[%0d.%0d]: got %h/%h want %h/%h", t, k, we_addr[k], we_data[k], ea, wq[k]); end
        end
      end else begin
        exp_r.delete();
        for (int unsigned k = 0; k < n; k++) begin ea = a + AW'(k); exp_r.push_back(mem[ea]); end
        do_read(a, b, to);
        checks++;
        if (to || re_addr.size() != n || tx_bits.size() != n * DW || done_cnt != 1)
          begin errors++; $display("FAIL rnd_rd_count[%0d]: got re=%0d bits=%0d done=%0d want %0d/%0d/1", t, re_addr.size(), tx_bits.size(), done_cnt, n, n*DW); end
        else for (int unsigned k = 0; k < n; k++) begin
          for (int unsigned j = 0; j < DW; j++) got[j] = tx_bits[k*DW + j];
          ea = a + AW'(k);
          checks++;
          if (re_addr[k] !== ea || got !== exp_r[k])
            begin errors++; $display("FAIL rnd_rd_beat[%0d.%0d]: got %h/%h want %h/%h", t, k, re_addr[k], got, ea, exp_r[k]); end
        end
      end
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = DW'($urandom);
    #3;
    test_reset();
    test_single_write();
    test_read_burst();
    test_wrap_zero();
    test_backpressure();
    test_abort_illegal();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/slave_in.md
Name: slave_in

Overview:
- Slave-side endpoint of the serial system bus: receives the bit-serial address, burst count and write data shifted by a bus master; performs local memory writes or reads; shifts read data back.
- Sits between the bus decoder/arbiter fabric and one slave memory.
- Signals rx_done to the master when a whole burst completes.

Parameters:
- ADDR_W, 12, serial address width and burst-count width.
- DATA_W, 8, data beat width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- sel  in  1  slave selected by the bus decoder
- master_valid  in  1  master is driving a valid transfer
- master_ready  in  1  master can accept serial read data
- write_en  in  1  write command, sampled at start
- read_en  in  1  read command, sampled at start
- rx_address  in  1  serial address, LSB first
- rx_burst_number  in  1  serial burst count, LSB first, concurrent with address
- rx_data  in  1  serial write data, LSB first
- slave_ready  out  1  slave can accept a transfer
- slave_valid  out  1  tx_data carries a valid read bit
- tx_data  out  1  serial read data, LSB first
- rx_done  out  1  one-cycle burst-complete pulse
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write strobe, one cycle
- mem_re  out  1  memory read strobe, one cycle
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_re

Behaviour:
- Reset (reset=0, async): state IDLE. All outputs 0, including slave_ready. All counters and shift registers cleared.
- Reset mid-burst: the burst is abandoned. No rx_done is issued.
- States: IDLE, ADDR, WDATA, WRITE, RREQ, RCAP, RDATA, DONE.
- IDLE:
  - slave_ready = sel.
  - Start condition: sel & master_valid & slave_ready & (write_en ^ read_en).
  - On start: latch op, sample bit0 of rx_address and rx_burst_number, go to ADDR.
  - If write_en==read_en, the request is ignored and the block stays in IDLE.
- ADDR:
  - Samples bits 1..ADDR_W-1 on consecutive cycles; ADDR_W cycles total including the start cycle.
  - slave_ready=0 from ADDR until the return to IDLE.
  - Beat count = burst value. A burst value of 0 is treated as 1 beat.
  - Write op goes to WDATA; read op goes to RREQ.
- WDATA: samples DATA_W bits on consecutive cycles, starting the cycle after the last address bit. Then goes to WRITE.
- WRITE: mem_we=1 for exactly one cycle with mem_addr and mem_wdata stable.
- RREQ: mem_re=1 for one cycle. Goes to RCAP.
- RCAP: captures mem_rdata. Goes to RDATA.
- RDATA:
  - Waits while master_ready=0, with slave_valid=0.
  - Once master_ready=1, drives slave_valid=1 for DATA_W consecutive cycles, tx_data LSB first.
  - master_ready dropping mid-byte pauses the shift. slave_valid goes low and the bit position is held.
- After each beat:
  - Decrement remaining beats.
  - mem_addr += 1, modulo 2^ADDR_W (0xFFF wraps to 0x000).
  - If beats remain, go back to WDATA or RREQ; otherwise go to DONE.
- DONE: rx_done=1 for one cycle, then IDLE.
- sel dropping in any non-IDLE state: next state IDLE. No further mem_we/mem_re, no rx_done.
- Simultaneous events:
  - sel drop in the same cycle as the WRITE state: the write still completes, then the block aborts.
  - reset overrides everything.
- Latencies:
  - Write beat: DATA_W+1 cycles.
  - Read beat: 2 + DATA_W cycles minimum.
  - Start to first mem_we: ADDR_W + DATA_W cycles.

Decomposition:
- Shared package bus_pkg holds:
  - state enum
  - ADDR_W/DATA_W defaults
  - op encoding (OP_WRITE, OP_READ)
- One natural sub-module: bus_shift_reg, a parameterised width, LSB-first shift register with enable and serial-in/serial-out. It is instantiated for address, burst, write data and read data.

Test Plan:
- Reset: hold reset=0 with random inputs → all outputs 0. Release with sel=1 → slave_ready=1 next cycle.
- Single write: addr 0x5C3, burst 1, data 0xA5 → one mem_we with mem_addr=0x5C3, mem_wdata=0xA5; rx_done one cycle later; slave_ready back to 1.
- Read burst: addr 0xE5C, burst 3, mem returns 0x11/0x22/0x33 → mem_re at 0xE5C, 0xE5D, 0xE5E; tx_data serialises 0x11, 0x22, 0x33 LSB first; one rx_done.
- Wrap and zero burst:
  - addr 0xFFF, burst 2, write 0x01/0x02 → writes at 0xFFF then 0x000.
  - burst 0 → exactly one write.
- Backpressure: read with master_ready dropped for 5 cycles after bit 3 → slave_valid low 5 cycles; byte intact.
- Abort and illegal:
  - sel drops during WDATA → no mem_we, no rx_done, IDLE.
  - write_en=read_en=1 at start → ignored.
  - reset mid-burst → immediate clear.
